wm_sequencer: RTL and testbench

WM_SEQUENCER -- requirements
Module: wm_sequencer

---
 rtl/wm_pkg.sv | 43 ++++
 rtl/wm_watchdog.sv | 26 ++
 rtl/wm_sequencer.sv | 103 ++++++++++
 tb/tb_wm_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine sequencer and its Timer stage:
// phase codes, parameter defaults and the per-phase actuator decode.
package wm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      HEAT   = 3'd2,
      WASH   = 3'd3,
      DRAIN  = 3'd4,
      SPIN   = 3'd5,
      FINISH = 3'd6,
      FAULT  = 3'd7
   } wm_state_e;

   localparam int unsigned RINSE_CYCLES_DEFAULT = 2;
   localparam int unsigned WDOG_LIMIT_DEFAULT   = 1023;

   typedef struct packed {
      logic water_valve;
      logic heater;
      logic motor;
      logic drain_valve;
      logic door_lock;
      logic done;
      logic fault;
   } wm_act_t;

   function automatic wm_act_t act_of(input wm_state_e s);
      wm_act_t a;
      a             = '0;
      a.water_valve = (s == FILL);
      a.heater      = (s == HEAT);
      a.motor       = (s == WASH) || (s == SPIN);
      a.drain_valve = (s == DRAIN) || (s == SPIN) || (s == FAULT);
      a.door_lock   = (s == FILL) || (s == HEAT) || (s == WASH) ||
                      (s == DRAIN) || (s == SPIN);
      a.done        = (s == FINISH);
      a.fault       = (s == FAULT);
      return a;
   endfunction

endpackage

// File: rtl/wm_watchdog.sv
// Phase watchdog: counts cycles spent in the current timed phase and flags
// the LIMIT-th consecutive cycle so the sequencer can leave at its closing edge.
module wm_watchdog
   import wm_pkg::*;
#(
   parameter int unsigned LIMIT = WDOG_LIMIT_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear || !enable) count <= '0;
      else                           count <= count + W'(1);
   end

   assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/wm_sequencer.sv
// Washing-machine program sequencer: Moore FSM over FILL/HEAT/WASH/DRAIN
// passes with cancel, door-open and watchdog fault handling.
module wm_sequencer
   import wm_pkg::*;
#(
   parameter int unsigned RINSE_CYCLES = RINSE_CYCLES_DEFAULT,
   parameter int unsigned WDOG_LIMIT   = WDOG_LIMIT_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       door_closed,
   input  logic       cancel,
   input  logic       sig_Full,
   input  logic       sig_Temperature,
   input  logic       sig_Completed,
   output logic [2:0] state,
   output logic       water_valve,
   output logic       heater,
   output logic       motor,
   output logic       drain_valve,
   output logic       door_lock,
   output logic       done,
   output logic       fault
);

   localparam logic [2:0] RINSE3 = 3'(RINSE_CYCLES);
   localparam logic [3:0] RINSE4 = 4'(RINSE_CYCLES);

   wm_state_e  state_q, nxt;
   logic [2:0] pass_q;
   logic [3:0] pass_inc;
   logic       timed, cancel_hit, wd_expired;
   wm_act_t    acts;

   assign timed    = (state_q == FILL) || (state_q == HEAT) || (state_q == WASH) ||
                     (state_q == DRAIN) || (state_q == SPIN);
   assign pass_inc = {1'b0, pass_q} + 4'd1;

   wm_watchdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (nxt != state_q),
      .enable  (timed),
      .expired (wd_expired)
   );

   always_comb begin
      nxt        = state_q;
      cancel_hit = 1'b0;
      if (timed && !door_closed) begin
         nxt = FAULT;
      end else if (wd_expired) begin
         nxt = FAULT;
      end else if (cancel && timed && state_q != DRAIN) begin
         nxt        = DRAIN;
         cancel_hit = 1'b1;
      end else begin
         case (state_q)
            IDLE:   if (start && door_closed) nxt = FILL;
            FILL:   if (sig_Full) nxt = (pass_q == 3'd0) ? HEAT : WASH;
            HEAT:   if (sig_Temperature) nxt = WASH;
            WASH:   if (sig_Completed) nxt = DRAIN;
            // A pass count already at RINSE_CYCLES only happens after cancel.
            DRAIN:  if (sig_Completed) begin
                       if (pass_q >= RINSE3)      nxt = IDLE;
                       else if (pass_inc < RINSE4) nxt = FILL;
                       else                        nxt = SPIN;
                    end
            SPIN:   if (sig_Completed) nxt = FINISH;
            FINISH: nxt = IDLE;
            FAULT:  nxt = FAULT;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         pass_q  <= '0;
         acts    <= '0;
      end else begin
         state_q <= nxt;
         acts    <= act_of(nxt);
         if (nxt == IDLE)
            pass_q <= '0;
         else if (cancel_hit)
            pass_q <= RINSE3;
         else if (state_q == DRAIN && nxt != DRAIN && nxt != FAULT)
            pass_q <= pass_inc[2:0];
      end
   end

   assign state       = state_q;
   assign water_valve = acts.water_valve;
   assign heater      = acts.heater;
   assign motor       = acts.motor;
   assign drain_valve = acts.drain_valve;
   assign door_lock   = acts.door_lock;
   assign done        = acts.done;
   assign fault       = acts.fault;

endmodule

// File: tb/tb_wm_sequencer.sv
// Self-checking bench for wm_sequencer: directed program scenarios followed by
// randomized inputs compared against a phase-level reference model.
module tb_wm_sequencer;

   localparam int RINSE = 2;
   localparam int LIMIT = 1023;

   logic clock = 1'b0;
   logic reset, start, door_closed, cancel, sig_Full, sig_Temperature, sig_Completed;
   logic [2:0] state, w_state;
   logic water_valve, heater, motor, drain_valve, door_lock, done, fault;
   logic w_water_valve, w_heater, w_motor, w_drain_valve, w_door_lock, w_done, w_fault;

   int checks = 0;
   int passes = 0;

   int m_phase = 0;
   int m_pass  = 0;
   int m_age   = 0;

   always #5 clock = ~clock;

   wm_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .door_closed(door_closed),
      .cancel(cancel), .sig_Full(sig_Full), .sig_Temperature(sig_Temperature),
      .sig_Completed(sig_Completed), .state(state), .water_valve(water_valve),
      .heater(heater), .motor(motor), .drain_valve(drain_valve),
      .door_lock(door_lock), .done(done), .fault(fault)
   );

   wm_sequencer #(.RINSE_CYCLES(2), .WDOG_LIMIT(8)) dut_w (
      .clock(clock), .reset(reset), .start(start), .door_closed(door_closed),
      .cancel(cancel), .sig_Full(sig_Full), .sig_Temperature(sig_Temperature),
      .sig_Completed(sig_Completed), .state(w_state), .water_valve(w_water_valve),
      .heater(w_heater), .motor(w_motor), .drain_valve(w_drain_valve),
      .door_lock(w_door_lock), .done(w_done), .fault(w_fault)
   );

   wire [9:0] obs_vec = {state, water_valve, heater, motor, drain_valve, door_lock, done, fault};
   wire [9:0] w_vec   = {w_state, w_water_valve, w_heater, w_motor, w_drain_valve,
                         w_door_lock, w_done, w_fault};

   // Expected {phase, actuators, done, fault} for a given phase number.
   function automatic logic [9:0] expect_vec(input int p);
      logic [2:0] code;
      code = 3'(p);
      return {code, p == 1, p == 2, p == 3 || p == 5, p == 4 || p == 5 || p == 7,
              p >= 1 && p <= 5, p == 6, p == 7};
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Program-level model: phases advance by the washer's rules; m_age counts
   // how many cycles the current timed phase has already been shown.
   task automatic model(input bit r, s, d, c, f, t, k);
      int  np;
      bit  timed;
      if (r) begin
         m_phase = 0; m_pass = 0; m_age = 0;
         return;
      end
      timed = (m_phase >= 1 && m_phase <= 5);
      np    = m_phase;
      if (timed && !d)                                 np = 7;
      else if (timed && m_age + 1 >= LIMIT)            np = 7;
      else if (c && timed && m_phase != 4) begin
         np = 4; m_pass = RINSE;
      end else begin
         case (m_phase)
            0: if (s && d) np = 1;
            1: if (f) np = (m_pass == 0) ? 2 : 3;
            2: if (t) np = 3;
            3: if (k) np = 4;
            4: if (k) begin
                  if (m_pass >= RINSE)        np = 0;
                  else if (m_pass + 1 < RINSE) np = 1;
                  else                         np = 5;
                  m_pass = m_pass + 1;
               end
            5: if (k) np = 6;
            6: np = 0;
            default: np = 7;
         endcase
      end
      m_age   = (np != m_phase || !(np >= 1 && np <= 5)) ? 0 : m_age + 1;
      m_phase = np;
      if (np == 0) m_pass = 0;
   endtask

   task automatic step(input string tag, input bit r, s, d, c, f, t, k);
      reset = r; start = s; door_closed = d; cancel = c;
      sig_Full = f; sig_Temperature = t; sig_Completed = k;
      model(r, s, d, c, f, t, k);
      @(posedge clock);
      #1;
      check(tag, obs_vec, expect_vec(m_phase));
   endtask

   initial begin
      int exp_states [10] = '{1, 2, 3, 4, 1, 3, 4, 5, 6, 0};
      bit run_in [10][3]  = '{'{0,0,0}, '{1,0,0}, '{0,1,0}, '{0,0,1}, '{0,0,1},
                              '{1,0,0}, '{0,0,1}, '{0,0,1}, '{0,0,1}, '{0,0,0}};
      int done_count;

      reset = 1'b1; start = 1'b0; door_closed = 1'b1; cancel = 1'b0;
      sig_Full = 1'b0; sig_Temperature = 1'b0; sig_Completed = 1'b0;

      // Reset state
      step("reset0", 1, 0, 1, 0, 0, 0, 0);
      step("reset1", 1, 1, 1, 0, 1, 1, 1);
      check("reset_const", obs_vec, 10'b0);

      // Normal two-pass program
      done_count = 0;
      for (int i = 0; i < 10; i++) begin
         step("run", 0, i == 0, 1, 0, run_in[i][0], run_in[i][1], run_in[i][2]);
         check("run_state", {7'b0, state}, 10'(exp_states[i]));
         if (done) done_count++;
      end
      check("done_once", 10'(done_count), 10'd1);

      // Door opened mid-WASH faults and latches
      step("door_s", 0, 1, 1, 0, 0, 0, 0);
      step("door_f", 0, 0, 1, 0, 1, 0, 0);
      step("door_h", 0, 0, 1, 0, 0, 1, 0);
      step("door_open", 0, 0, 0, 0, 0, 0, 0);
      check("door_fault", obs_vec, 10'b111_0001_001);
      for (int i = 0; i < 4; i++) step("fault_hold", 0, 1, 1, i[0], 1, 1, 1);
      check("fault_hold_const", obs_vec, 10'b111_0001_001);
      step("fault_reset", 1, 0, 1, 0, 0, 0, 0);
      check("fault_reset_const", obs_vec, 10'b0);

      // Cancel beats sig_Completed in WASH, then drains straight to IDLE
      step("cxl_s", 0, 1, 1, 0, 0, 0, 0);
      step("cxl_f", 0, 0, 1, 0, 1, 0, 0);
      step("cxl_h", 0, 0, 1, 0, 0, 1, 0);
      step("cxl_hit", 0, 0, 1, 1, 0, 0, 1);
      check("cxl_drain", {7'b0, state}, 10'd4);
      step("cxl_exit", 0, 0, 1, 0, 0, 0, 1);
      check("cxl_idle", obs_vec, 10'b0);
      step("cxl_after", 0, 0, 1, 0, 0, 0, 0);
      check("cxl_nodone", {9'b0, done}, 10'b0);

      // Watchdog on the WDOG_LIMIT=8 instance: 8 cycles in HEAT, then FAULT
      step("wd_rst", 1, 0, 1, 0, 0, 0, 0);
      step("wd_s", 0, 1, 1, 0, 0, 0, 0);
      step("wd_f", 0, 0, 1, 0, 1, 0, 0);
      check("wd_heat0", w_vec, 10'b010_0100_100);
      for (int i = 1; i < 8; i++) begin
         step("wd_wait", 0, 0, 1, 0, 0, 0, 0);
         check("wd_heat", w_vec, 10'b010_0100_100);
      end
      step("wd_trip", 0, 0, 1, 0, 0, 0, 0);
      check("wd_fault", w_vec, 10'b111_0001_001);
      check("wd_default_stays", {7'b0, state}, 10'd2);

      // Completed in FILL ignored; reset in SPIN clears everything
      step("fl_rst", 1, 0, 1, 0, 0, 0, 0);
      step("fl_s", 0, 1, 1, 0, 0, 0, 0);
      step("fl_c", 0, 0, 1, 0, 0, 0, 1);
      check("fill_ignores_c", {7'b0, state}, 10'd1);
      step("sp_f", 0, 0, 1, 0, 1, 0, 0);
      step("sp_h", 0, 0, 1, 0, 0, 1, 0);
      step("sp_w", 0, 0, 1, 0, 0, 0, 1);
      step("sp_d1", 0, 0, 1, 0, 0, 0, 1);
      step("sp_fl", 0, 0, 1, 0, 1, 0, 0);
      step("sp_w2", 0, 0, 1, 0, 0, 0, 1);
      step("sp_d2", 0, 0, 1, 0, 0, 0, 1);
      check("in_spin", {7'b0, state}, 10'd5);
      step("sp_rst", 1, 1, 1, 1, 1, 1, 1);
      check("spin_reset", obs_vec, 10'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step("random",
              $urandom_range(0, 59) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 79) != 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
